// File: rtl/blink_pkg.sv
// Shared types and helpers for the multi-channel blink machine.
// Build option BLINK_INFINITE_EN is consumed by blink_machine_multi, not here.
package blink_pkg;

   typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

   localparam int MIN_HALF = 2;

   // Cycles per ON or OFF phase, also half the clk_1hz period.
   function automatic int calc_half(input int clk_freq_hz, input int tick_hz);
      return clk_freq_hz / (2 * tick_hz);
   endfunction

endpackage

// File: rtl/blink_machine_multi_tick_gen.sv
// Modulo-HALF counter: wrap is high while the count sits at HALF-1, and the
// counter returns to zero on that edge or whenever clear is asserted.
module tick_gen #(
   parameter int HALF = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic wrap
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0] count;

   assign wrap = (count == CW'(HALF - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (wrap) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/blink_machine_multi.sv
// NUM_CH-channel LED blinker with programmable ON/OFF cycle count and a
// free-running clk_1hz debug output. Define BLINK_INFINITE_EN to add the stop
// port and make blink_count=0 blink until stopped.
module blink_machine_multi
   import blink_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ     = 1,
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  blink_count,
   input  logic [NUM_CH-1:0] ch_mask,
`ifdef BLINK_INFINITE_EN
   input  logic              stop,
`endif
   output logic [NUM_CH-1:0] out,
   output logic              clk_1hz,
   output logic              busy,
   output logic              done
);

   // HALF must be at least MIN_HALF for the phase timing to hold.
   localparam int HALF = calc_half(CLK_FREQ_HZ, TICK_HZ);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  remaining, remaining_nxt;
   logic [NUM_CH-1:0] mask, mask_nxt;
   logic              pre_wrap;
   logic              phase_wrap;
   logic              phase_clear;
   logic              accept;
   logic              stop_req;
   logic              infinite;

   tick_gen #(.HALF(HALF)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .wrap  (pre_wrap)
   );

   tick_gen #(.HALF(HALF)) u_phase_timer (
      .clk   (clk),
      .reset (reset),
      .clear (phase_clear),
      .wrap  (phase_wrap)
   );

`ifdef BLINK_INFINITE_EN
   assign accept   = start;
   assign stop_req = stop;

   // A zero count at acceptance selects endless blinking for the whole run.
   always_ff @(posedge clk) begin
      if (reset) begin
         infinite <= 1'b0;
      end else if (state == IDLE && accept) begin
         infinite <= (blink_count == '0);
      end
   end
`else
   assign accept   = start && (blink_count != '0);
   assign stop_req = 1'b0;
   assign infinite = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_1hz <= 1'b0;
      end else if (pre_wrap) begin
         clk_1hz <= ~clk_1hz;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         mask      <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         mask      <= mask_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      mask_nxt      = mask;
      phase_clear   = 1'b0;
      out           = '0;
      busy          = 1'b0;
      done          = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt     = ON;
               remaining_nxt = blink_count;
               mask_nxt      = ch_mask;
               phase_clear   = 1'b1;
            end
         end
         ON: begin
            out  = mask;
            busy = 1'b1;
            if (stop_req) begin
               state_nxt = DONE;
            end else if (phase_wrap) begin
               state_nxt   = OFF;
               phase_clear = 1'b1;
            end
         end
         OFF: begin
            busy = 1'b1;
            if (stop_req) begin
               state_nxt = DONE;
            end else if (phase_wrap) begin
               phase_clear = 1'b1;
               if (!infinite && remaining == CNT_W'(1)) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ON;
                  if (!infinite) begin
                     remaining_nxt = remaining - CNT_W'(1);
                  end
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_blink_machine_multi.sv
// Table-driven bench for blink_machine_multi at HALF=4; every vector is checked
// one edge after it is driven, and clk_1hz is predicted from edges since reset.
module tb_blink_machine_multi;

   localparam int CLK_FREQ_HZ = 8;
   localparam int TICK_HZ     = 1;
   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 4;
   localparam int HALF        = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  blink_count = '0;
   logic [NUM_CH-1:0] ch_mask = '0;
   logic [NUM_CH-1:0] out;
   logic              clk_1hz;
   logic              busy;
   logic              done;
`ifdef BLINK_INFINITE_EN
   logic              stop = 1'b0;
`endif

   always #5 clk = ~clk;

   blink_machine_multi #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .TICK_HZ     (TICK_HZ),
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .blink_count (blink_count),
      .ch_mask     (ch_mask),
`ifdef BLINK_INFINITE_EN
      .stop        (stop),
`endif
      .out         (out),
      .clk_1hz     (clk_1hz),
      .busy        (busy),
      .done        (done)
   );

   typedef struct packed {
      logic       rst;
      logic       start;
      logic       stop;
      logic [3:0] cnt;
      logic [3:0] mask;
      logic [3:0] out;
      logic       busy;
      logic       done;
      logic [3:0] tag;
   } vec_t;

   typedef struct packed {
      logic [3:0] out;
      logic       busy;
      logic       done;
      logic       clk_1hz;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   string scen[16];
   int    total = 0;
   int    bad   = 0;
   int    edges = 0;

   task automatic addVec(input logic rst, input logic st, input logic sp,
                         input logic [3:0] cnt, input logic [3:0] mk,
                         input logic [3:0] eo, input logic eb, input logic ed,
                         input logic [3:0] tag);
      vec_t v;
      v = '{rst: rst, start: st, stop: sp, cnt: cnt, mask: mk,
            out: eo, busy: eb, done: ed, tag: tag};
      vecs.push_back(v);
   endtask

   task automatic addIdle(input int k, input logic [3:0] tag);
      for (int i = 0; i < k; i++) addVec(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, tag);
   endtask

   // One complete run of n ON/OFF pairs: accept at j=0, done sampled at j=2*n*HALF.
   task automatic addRun(input int n, input logic [3:0] m, input bit noise,
                         input bit hold, input logic [3:0] tag);
      logic       st;
      logic [3:0] c, mk, eo;
      logic       eb, ed;
      for (int j = 0; j <= 2 * n * HALF; j++) begin
         st = (j == 0) || hold || (noise && (j % 5 == 0) && (j < 2 * n * HALF));
         c  = (j != 0 && noise) ? 4'd5 : 4'(n);
         mk = (j != 0 && noise) ? 4'b1111 : m;
         if (j < 2 * n * HALF) begin
            eo = (((j / HALF) % 2) == 0) ? m : 4'd0;
            eb = 1'b1;
            ed = 1'b0;
         end else begin
            eo = 4'd0;
            eb = 1'b0;
            ed = 1'b1;
         end
         addVec(0, st, 0, c, mk, eo, eb, ed, tag);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(negedge clk);
      reset       = v.rst;
      start       = v.start;
      blink_count = v.cnt;
      ch_mask     = v.mask;
`ifdef BLINK_INFINITE_EN
      stop        = v.stop;
`endif
      if (v.rst) edges = 0;
      else edges++;
      e.out     = v.out;
      e.busy    = v.busy;
      e.done    = v.done;
      e.clk_1hz = ((edges / HALF) % 2) == 1;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input int idx, input logic [3:0] tag);
      exp_t e;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({out, busy, done, clk_1hz} !== e) begin
         bad++;
         $display("[TB] FAIL %s[%0d]: got out=%b busy=%b done=%b clk_1hz=%b, want out=%b busy=%b done=%b clk_1hz=%b",
                  scen[tag], idx, out, busy, done, clk_1hz, e.out, e.busy, e.done, e.clk_1hz);
      end
   endtask

   initial begin
      scen[0] = "reset";
      scen[1] = "idle";
      scen[2] = "run2";
      scen[3] = "zero_cnt";
      scen[4] = "ignore_start";
      scen[5] = "held_start";
      scen[6] = "mid_reset";
      scen[7] = "mask0";
      scen[8] = "max_cnt";
      scen[9] = "infinite";

      for (int i = 0; i < 3; i++) addVec(1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0);
      addIdle(10, 4'd1);

      addRun(2, 4'b1010, 0, 0, 4'd2);
      addIdle(2, 4'd2);

`ifndef BLINK_INFINITE_EN
      for (int i = 0; i < 3; i++) addVec(0, 1, 0, 4'd0, 4'b1111, 4'd0, 0, 0, 4'd3);
      addIdle(2, 4'd3);
`endif

      addRun(3, 4'b1010, 1, 0, 4'd4);
      addIdle(2, 4'd4);

      addRun(1, 4'b0001, 0, 1, 4'd5);
      addVec(0, 1, 0, 4'd1, 4'b0001, 4'd0, 0, 0, 4'd5);
      addRun(1, 4'b0001, 0, 0, 4'd5);
      addIdle(2, 4'd5);

      for (int j = 0; j < 10; j++)
         addVec(0, j == 0, 0, 4'd2, 4'b1010,
                (((j / HALF) % 2) == 0) ? 4'b1010 : 4'b0000, 1, 0, 4'd6);
      addVec(1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd6);
      addVec(1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd6);
      addIdle(3, 4'd6);
      addRun(2, 4'b1010, 0, 0, 4'd6);
      addIdle(2, 4'd6);

      addRun(1, 4'b0000, 0, 0, 4'd7);
      addIdle(1, 4'd7);

      addRun(15, 4'b0110, 0, 0, 4'd8);
      addIdle(2, 4'd8);

`ifdef BLINK_INFINITE_EN
      addVec(0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 4'd9);
      for (int j = 0; j <= 40; j++)
         addVec(0, j == 0, 0, 4'd0, 4'b1100,
                (((j / HALF) % 2) == 0) ? 4'b1100 : 4'b0000, 1, 0, 4'd9);
      addVec(0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 1, 4'd9);
      addVec(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd9);
      addVec(0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 4'd9);
      addIdle(2, 4'd9);
`endif

      $display("[TB] applying %0d vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i].tag);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/blink_machine_multi.md
Name: blink_machine_multi

Overview:
- Parametrised successor of the single-LED blinking machine.
- Drives NUM_CH LED outputs that blink together, gated per channel by a mask latched at start.
- Blinks for a programmable number of ON/OFF cycles, then raises a one-cycle done pulse.
- Also produces the free-running square wave clk_1hz for board-level debug; sits between the push-button/control logic and the LED pins.

Parameters:
- CLK_FREQ_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, blink and clk_1hz frequency; each ON and each OFF phase lasts HALF = CLK_FREQ_HZ/(2*TICK_HZ) cycles; HALF >= 2 required.
- NUM_CH, 4, number of LED channels.
- CNT_W, 4, width of the blink count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled start request.
- blink_count  in  CNT_W  number of ON/OFF cycles; sampled with start.
- ch_mask  in  NUM_CH  channel enable mask; sampled with start.
- out  out  NUM_CH  LED outputs.
- clk_1hz  out  1  free-running 50% square wave at TICK_HZ.
- busy  out  1  high in ON/OFF.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: out=0, clk_1hz=0, busy=0, done=0, FSM=IDLE, all counters 0; reset has priority over every other input.
- Free-running prescaler: counts 0..HALF-1 and wraps; clk_1hz toggles on the edge where the count wraps, giving period 2*HALF cycles. It is never cleared by start.
- Phase timer: a separate counter, cleared on start acceptance and at every phase change. A phase ends on the edge where the timer = HALF-1.
- FSM states: IDLE, ON, OFF, DONE.
- IDLE: start=1 and blink_count!=0 at edge k:
  - latch remaining=blink_count and mask=ch_mask
  - go to ON
  - out=mask visible from edge k.
  - start with blink_count=0 is ignored.
- ON: out=mask; at phase end go to OFF with out=0.
- OFF: out=0; at phase end:
  - if remaining==1, go to DONE;
  - otherwise decrement remaining and go to ON.
- DONE: lasts exactly 1 cycle with done=1 and busy=0, then IDLE. A start held high is accepted again on the next IDLE cycle.
- Latency: done asserts 2*N*HALF cycles after the acceptance edge (N = latched count).
- start, blink_count and ch_mask are ignored outside IDLE; the latched values are not disturbed.
- ch_mask=0 with a valid count: the full timing runs, out stays 0, done still pulses.
- blink_count of all ones (2^CNT_W-1) must work without wrap; remaining is CNT_W bits wide.
- Reset mid-operation: on the next edge, out=0, busy=0, done is not pulsed, and the FSM returns to IDLE.

Optional Feature:
- Macro BLINK_INFINITE_EN.
- When defined:
  - adds input port stop (1 bit);
  - blink_count=0 at start means blink indefinitely, remaining is never decremented, and OFF always returns to ON;
  - stop=1 while in ON or OFF (any count) forces out=0 on the next edge and enters DONE (done pulses once);
  - stop in IDLE or DONE has no effect.
- When undefined: no stop port, and blink_count=0 is ignored as above.

Decomposition:
- Package blink_pkg:
  - state enum (IDLE, ON, OFF, DONE);
  - a function computing HALF from CLK_FREQ_HZ/TICK_HZ;
  - a localparam for the minimum legal HALF (2).
- One sub-module, tick_gen: a parametrised modulo-HALF counter with clear input and a wrap pulse output.
  - One instance is free-running and drives the clk_1hz toggle.
  - One instance is cleared on start and phase change and times the phases.

Test Plan (CLK_FREQ_HZ=8, TICK_HZ=1 so HALF=4; NUM_CH=4, CNT_W=4):
- Reset released, no start -> out=0, busy=0, and clk_1hz toggles every 4 cycles (period 8) from reset release.
- start one cycle, blink_count=2, ch_mask=4'b1010 -> out=1010 for 4 cycles, 0 for 4, 1010 for 4, 0 for 4; done pulses for 1 cycle 16 cycles after acceptance; busy high for exactly those 16 cycles.
- start with blink_count=0 -> FSM stays IDLE, busy=0, no done pulse.
- blink_count=3 running, start again with ch_mask=4'b1111 mid-run -> ignored; out keeps 1010; done arrives at cycle 24.
- reset asserted during the second ON phase -> next edge out=0, busy=0, no done; a fresh start then behaves as in the blink_count=2 scenario.
- BLINK_INFINITE_EN defined, blink_count=0 -> blinks beyond 15 cycles; stop pulsed while in ON -> out=0 next edge, done pulses once, then IDLE.
